dmem_arbiter: RTL and testbench

- Shares the single-port, synchronous-read data memory between the CPU MEM stage and an external DMA/loader port.
- Decides the memory owner each cycle, sequences the 1-cycle read latency, and routes read data back to the correct requester.
- Drives a stall to the pipeline hazard logic so the MEM stage holds while it waits.
- Bounds DMA starvation with a fairness counter.

---
 rtl/dmem_arbiter_if.sv | 45 ++++
 rtl/dmem_arbiter.sv | 91 +++++++++
 tb/tb_dmem_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU MEM stage, the DMA/loader port, the data memory and
// the arbiter that sits between them.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 19
);
    logic              cpu_memread;
    logic              cpu_memwrite;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_memread, cpu_memwrite, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_memread, cpu_memwrite, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port synchronous-read data memory between the CPU MEM
// stage and the DMA port, with bounded DMA starvation and read-data routing.
module dmem_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 19,
    parameter int STARVE_MAX = 4
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, CPU_RD, DMA_RD} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            state;
    logic [3:0]        starve_cnt;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dma_rdata_q;
    logic              cpu_req;
    logic              cpu_win;
    logic              dma_win;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v >= STARVE_LIM) ? STARVE_LIM : v + 4'd1;
    endfunction

    // In CPU_RD the request still on the bus belongs to the load whose data is returning.
    always_comb begin
        cpu_req = (bus.cpu_memread | bus.cpu_memwrite) && (state != CPU_RD);
        dma_win = bus.dma_req && (!cpu_req || (starve_cnt == STARVE_LIM));
        cpu_win = cpu_req && !dma_win;
    end

    // Combinational outputs are forced low while reset is held, independent of the clock.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.dma_gnt   = 1'b0;
        bus.cpu_stall = 1'b0;
        if (!reset) begin
            if (cpu_win) begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = bus.cpu_memwrite;
                bus.mem_addr  = bus.cpu_addr;
                bus.mem_wdata = bus.cpu_wdata;
            end else if (dma_win) begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = bus.dma_we;
                bus.mem_addr  = bus.dma_addr;
                bus.mem_wdata = bus.dma_wdata;
                bus.dma_gnt   = 1'b1;
            end
            bus.cpu_stall = cpu_req && (!cpu_win || !bus.cpu_memwrite);
        end
    end

    assign bus.cpu_rdata  = (state == CPU_RD) ? bus.mem_rdata : cpu_rdata_q;
    assign bus.dma_rdata  = (state == DMA_RD) ? bus.mem_rdata : dma_rdata_q;
    assign bus.dma_rvalid = (state == DMA_RD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            if (state == CPU_RD)
                cpu_rdata_q <= bus.mem_rdata;
            if (state == DMA_RD)
                dma_rdata_q <= bus.mem_rdata;

            if (cpu_win && !bus.cpu_memwrite)
                state <= CPU_RD;
            else if (dma_win && !bus.dma_we)
                state <= DMA_RD;
            else
                state <= IDLE;

            if (bus.dma_req && cpu_win)
                starve_cnt <= sat_inc(starve_cnt);
            else
                starve_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a synchronous-read memory model attached.
module tb_dmem_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 19;

    logic clk;
    logic reset;
    int   total;
    int   passes;
    int   fails;

    logic [DATA_W-1:0] mem [256];

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we)
                mem[bus.mem_addr] <= bus.mem_wdata;
            else
                bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.cpu_memread  = 1'b0;
        bus.cpu_memwrite = 1'b0;
        bus.cpu_addr     = '0;
        bus.cpu_wdata    = '0;
        bus.dma_req      = 1'b0;
        bus.dma_we       = 1'b0;
        bus.dma_addr     = '0;
        bus.dma_wdata    = '0;
    endtask

    initial begin
        total  = 0;
        passes = 0;
        fails  = 0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 19'h1ABCD;
        mem[8'h11] = 19'h2468A;
        bus.mem_rdata = '0;
        clear_inputs();
        reset = 1'b1;

        // Requests during reset must not reach the memory
        bus.cpu_memread = 1'b1;
        bus.dma_req     = 1'b1;
        #2;
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_stall", bus.cpu_stall, 0);
        chk("rst_gnt", bus.dma_gnt, 0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 0);
        chk("rst_dma_rvalid", bus.dma_rvalid, 0);
        chk("rst_dma_rdata", bus.dma_rdata, 0);
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();

        // CPU load from 0x10
        @(negedge clk);
        bus.cpu_memread = 1'b1;
        bus.cpu_addr    = 8'h10;
        #2;
        chk("ld_stall", bus.cpu_stall, 1);
        chk("ld_en", bus.mem_en, 1);
        chk("ld_we", bus.mem_we, 0);
        chk("ld_addr", bus.mem_addr, 8'h10);
        @(negedge clk);
        #2;
        chk("ld_ret_stall", bus.cpu_stall, 0);
        chk("ld_ret_data", bus.cpu_rdata, 19'h1ABCD);
        chk("ld_ret_no_reissue", bus.mem_en, 0);
        @(negedge clk);
        clear_inputs();
        #2;
        chk("ld_hold_data", bus.cpu_rdata, 19'h1ABCD);
        chk("ld_idle_en", bus.mem_en, 0);

        // CPU store vs DMA read of the same address
        @(negedge clk);
        bus.cpu_memwrite = 1'b1;
        bus.cpu_addr     = 8'h20;
        bus.cpu_wdata    = 19'h00123;
        bus.dma_req      = 1'b1;
        bus.dma_we       = 1'b0;
        bus.dma_addr     = 8'h20;
        #2;
        chk("st_we", bus.mem_we, 1);
        chk("st_wdata", bus.mem_wdata, 19'h00123);
        chk("st_stall", bus.cpu_stall, 0);
        chk("st_dma_gnt", bus.dma_gnt, 0);
        @(negedge clk);
        bus.cpu_memwrite = 1'b0;
        #2;
        chk("dmard_gnt", bus.dma_gnt, 1);
        chk("dmard_we", bus.mem_we, 0);
        chk("dmard_addr", bus.mem_addr, 8'h20);
        @(negedge clk);
        bus.dma_req = 1'b0;
        #2;
        chk("dmard_rvalid", bus.dma_rvalid, 1);
        chk("dmard_rdata", bus.dma_rdata, 19'h00123);
        @(negedge clk);
        #2;
        chk("dmard_rvalid_pulse", bus.dma_rvalid, 0);
        chk("dmard_rdata_hold", bus.dma_rdata, 19'h00123);

        // Starvation: CPU stores every cycle while DMA write waits
        @(negedge clk);
        clear_inputs();
        bus.cpu_memwrite = 1'b1;
        bus.cpu_addr     = 8'h31;
        bus.cpu_wdata    = 19'h0AAAA;
        bus.dma_req      = 1'b1;
        bus.dma_we       = 1'b1;
        bus.dma_addr     = 8'h30;
        bus.dma_wdata    = 19'h05555;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk($sformatf("starve_cpu%0d_gnt", i), bus.dma_gnt, 0);
            chk($sformatf("starve_cpu%0d_addr", i), bus.mem_addr, 8'h31);
            @(negedge clk);
        end
        #2;
        chk("starve_dma_gnt", bus.dma_gnt, 1);
        chk("starve_cpu_stall", bus.cpu_stall, 1);
        chk("starve_dma_addr", bus.mem_addr, 8'h30);
        @(negedge clk);
        bus.dma_req = 1'b0;
        #2;
        chk("starve_after_stall", bus.cpu_stall, 0);
        chk("starve_after_addr", bus.mem_addr, 8'h31);
        @(negedge clk);
        bus.dma_req = 1'b1;
        #2;
        chk("starve_cnt_cleared", bus.dma_gnt, 0);

        // Back-to-back: CPU load then DMA write during the data return
        @(negedge clk);
        clear_inputs();
        bus.cpu_memread = 1'b1;
        bus.cpu_addr    = 8'h11;
        bus.dma_req     = 1'b1;
        bus.dma_we      = 1'b1;
        bus.dma_addr    = 8'h40;
        bus.dma_wdata   = 19'h07777;
        #2;
        chk("b2b_stall", bus.cpu_stall, 1);
        chk("b2b_first_gnt", bus.dma_gnt, 0);
        chk("b2b_first_addr", bus.mem_addr, 8'h11);
        @(negedge clk);
        #2;
        chk("b2b_dma_gnt", bus.dma_gnt, 1);
        chk("b2b_dma_we", bus.mem_we, 1);
        chk("b2b_dma_addr", bus.mem_addr, 8'h40);
        chk("b2b_ret_stall", bus.cpu_stall, 0);
        chk("b2b_ret_data", bus.cpu_rdata, 19'h2468A);
        @(negedge clk);
        clear_inputs();
        #2;
        chk("b2b_idle_en", bus.mem_en, 0);
        chk("b2b_data_hold", bus.cpu_rdata, 19'h2468A);
        @(negedge clk);
        bus.cpu_memread = 1'b1;
        bus.cpu_addr    = 8'h40;
        #2;
        chk("b2b_verify_stall", bus.cpu_stall, 1);
        @(negedge clk);
        #2;
        chk("b2b_verify_data", bus.cpu_rdata, 19'h07777);

        // Read and write together: write wins, no read return state
        @(negedge clk);
        clear_inputs();
        bus.cpu_memread  = 1'b1;
        bus.cpu_memwrite = 1'b1;
        bus.cpu_addr     = 8'h50;
        bus.cpu_wdata    = 19'h1F0F0;
        #2;
        chk("rw_we", bus.mem_we, 1);
        chk("rw_stall", bus.cpu_stall, 0);
        chk("rw_wdata", bus.mem_wdata, 19'h1F0F0);
        @(negedge clk);
        #2;
        chk("rw_no_cpu_rd", bus.mem_en, 1);
        chk("rw_no_cpu_rd_stall", bus.cpu_stall, 0);

        // Reset right after a DMA read grant
        @(negedge clk);
        clear_inputs();
        bus.dma_req  = 1'b1;
        bus.dma_we   = 1'b0;
        bus.dma_addr = 8'h50;
        #2;
        chk("rstrd_gnt", bus.dma_gnt, 1);
        #1;
        reset = 1'b1;
        #1;
        chk("rstrd_async_en", bus.mem_en, 0);
        chk("rstrd_async_gnt", bus.dma_gnt, 0);
        @(negedge clk);
        #2;
        chk("rstrd_rvalid", bus.dma_rvalid, 0);
        chk("rstrd_dma_rdata", bus.dma_rdata, 0);
        chk("rstrd_cpu_rdata", bus.cpu_rdata, 0);
        @(negedge clk);
        reset = 1'b0;
        bus.dma_req = 1'b0;
        #2;
        chk("rstrd_post_rvalid", bus.dma_rvalid, 0);
        chk("rstrd_post_en", bus.mem_en, 0);
        @(negedge clk);
        bus.cpu_memread = 1'b1;
        bus.cpu_addr    = 8'h10;
        #2;
        chk("rstrd_idle_stall", bus.cpu_stall, 1);
        @(negedge clk);
        clear_inputs();
        @(negedge clk);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
